// File: rtl/mvm_sequencer_if.sv
// mvm_sequencer_if: stream-in, MAC-side and result-out signals of the matrix-vector sequencer
//   s_data/s_valid/s_ready   : signed 14-bit input stream (weights, then vector elements)
//   mac_a/mac_b/mac_valid    : operands and valid strobe to the downstream MAC
//   mac_clear                : synchronous clear of the MAC accumulator
//   mac_f/mac_valid_out      : saturated accumulator and its per-product valid pulse
//   m_data/m_valid/m_ready   : signed 28-bit per-row result with ready/valid handshake
interface mvm_sequencer_if;
  logic signed [13:0] s_data;
  logic               s_valid;
  logic               s_ready;
  logic signed [13:0] mac_a;
  logic signed [13:0] mac_b;
  logic               mac_valid;
  logic               mac_clear;
  logic signed [27:0] mac_f;
  logic               mac_valid_out;
  logic signed [27:0] m_data;
  logic               m_valid;
  logic               m_ready;
  modport master (
    input  s_data, s_valid, mac_f, mac_valid_out, m_ready,
    output s_ready, mac_a, mac_b, mac_valid, mac_clear, m_data, m_valid
  );
  modport slave (
    output s_data, s_valid, mac_f, mac_valid_out, m_ready,
    input  s_ready, mac_a, mac_b, mac_valid, mac_clear, m_data, m_valid
  );
endinterface

// File: rtl/mvm_sequencer.sv
// mvm_sequencer: loads an MxN weight matrix once, then per N-vector drives an external MAC row by row
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : mvm_sequencer_if.master (input stream, MAC operands/clear/result, row output)
module mvm_sequencer #(
  parameter int M    = 4,
  parameter int N    = 4,
  parameter int RELU = 1
) (
  input  logic clk,
  input  logic reset,
  mvm_sequencer_if.master bus
);
  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [2:0] {LOAD_W, LOAD_X, CLEAR, WAIT, ISSUE, DRAIN, OUT} state_t;
  state_t             state_q;
  logic [RW-1:0]      r_q;
  logic [KW-1:0]      k_q;
  logic [KW-1:0]      dc_q;
  logic [2:0]         wc_q;
  logic signed [13:0] w_q [M][N];
  logic signed [13:0] x_q [N];
  logic               s_ready_q;
  logic               mac_valid_q;
  logic               mac_clear_q;
  logic signed [13:0] mac_a_q;
  logic signed [13:0] mac_b_q;
  logic               m_valid_q;
  logic signed [27:0] m_data_q;
  logic               s_fire;
  logic               k_last;
  logic               r_last;
  logic               dc_last;
  assign s_fire  = bus.s_valid & s_ready_q;
  assign k_last  = k_q == KW'(N - 1);
  assign r_last  = r_q == RW'(M - 1);
  assign dc_last = dc_q == KW'(N - 1);
  assign bus.s_ready   = s_ready_q;
  assign bus.mac_valid = mac_valid_q;
  assign bus.mac_clear = mac_clear_q;
  assign bus.mac_a     = mac_a_q;
  assign bus.mac_b     = mac_b_q;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_data    = m_data_q;
  // Register files carry no reset: their contents are undefined after an abort and always reloaded.
  always_ff @(posedge clk) begin
    if (s_fire && state_q == LOAD_W) w_q[r_q][k_q] <= bus.s_data;
    if (s_fire && state_q == LOAD_X) x_q[k_q] <= bus.s_data;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= LOAD_W;
      r_q         <= '0;
      k_q         <= '0;
      dc_q        <= '0;
      wc_q        <= '0;
      s_ready_q   <= 1'b0;
      mac_valid_q <= 1'b0;
      mac_clear_q <= 1'b1;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
    end else begin
      case (state_q)
        // r_q/k_q double as the row-major weight write index while loading.
        LOAD_W: begin
          s_ready_q   <= 1'b1;
          mac_clear_q <= 1'b0;
          if (s_fire) begin
            k_q <= k_last ? '0 : k_q + 1'b1;
            if (k_last) begin
              r_q <= r_last ? '0 : r_q + 1'b1;
              if (r_last) state_q <= LOAD_X;
            end
          end
        end
        LOAD_X: begin
          if (s_fire) begin
            k_q <= k_last ? '0 : k_q + 1'b1;
            if (k_last) begin
              state_q     <= CLEAR;
              s_ready_q   <= 1'b0;
              mac_clear_q <= 1'b1;
              r_q         <= '0;
            end
          end
        end
        CLEAR: begin
          mac_clear_q <= 1'b0;
          state_q     <= WAIT;
        end
        // The first product is launched on the WAIT exit edge so ISSUE holds exactly N valid cycles.
        WAIT: begin
          wc_q <= wc_q + 1'b1;
          if (wc_q == 3'd7) begin
            state_q     <= ISSUE;
            mac_valid_q <= 1'b1;
            mac_a_q     <= w_q[r_q][0];
            mac_b_q     <= x_q[0];
          end
        end
        ISSUE: begin
          if (k_last) begin
            state_q     <= DRAIN;
            mac_valid_q <= 1'b0;
            k_q         <= '0;
          end else begin
            k_q     <= k_q + 1'b1;
            mac_a_q <= w_q[r_q][k_q + 1'b1];
            mac_b_q <= x_q[k_q + 1'b1];
          end
        end
        DRAIN: begin
          if (bus.mac_valid_out) begin
            dc_q <= dc_last ? '0 : dc_q + 1'b1;
            if (dc_last) begin
              m_data_q  <= (RELU != 0 && bus.mac_f[27]) ? '0 : bus.mac_f;
              m_valid_q <= 1'b1;
              state_q   <= OUT;
            end
          end
        end
        OUT: begin
          if (bus.m_ready) begin
            m_valid_q <= 1'b0;
            if (r_last) begin
              r_q       <= '0;
              state_q   <= LOAD_X;
              s_ready_q <= 1'b1;
            end else begin
              r_q         <= r_q + 1'b1;
              state_q     <= CLEAR;
              mac_clear_q <= 1'b1;
            end
          end
        end
        default: state_q <= LOAD_W;
      endcase
    end
  end
endmodule
